mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32, as the address width of both masters and the memory port.
REQ-002 The block SHALL have the following ports; all widths are in bits and m0 and m1 have identical ports:
- clk  in  1  clock; the block is synchronous to its rising edge.
- reset  in  1  synchronous, active-high.
- mN_req  in  1  master N requests one access.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  32  write data.
- mN_wstrb  in  4  byte enables for writes.
- mN_gnt  out  1  request accepted; combinational pulse lasting one cycle.
- mN_rvalid  out  1  response pulse; it is the read-data valid or the write acknowledge.
- mN_rdata  out  32  read data, valid while mN_rvalid=1.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wstrb  out  4  memory byte enables.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after the address is presented.

Function
REQ-003 The FSM SHALL have three states, IDLE, ACCESS and RESP, with the sequence IDLE->ACCESS->RESP->IDLE, so each transaction occupies exactly 3 cycles.
REQ-004 In IDLE with at least one mN_req=1, the block SHALL assert the winner's mN_gnt in that same cycle, latch the winner's we, addr, wdata and wstrb, record the winner ID, and go to ACCESS.
REQ-005 In IDLE with no request, the block SHALL stay in IDLE with every gnt at 0.
REQ-006 gnt SHALL be asserted only in IDLE, and only to a requester whose req=1 in that cycle.
REQ-007 In ACCESS the block SHALL drive mem_addr, mem_wdata and mem_wstrb from the latched values, drive mem_we=latched we for exactly one cycle, and go to RESP.
REQ-008 Outside ACCESS the block SHALL hold mem_we=0 and mem_wstrb=0; mem_addr SHALL hold its last value.
REQ-009 In RESP the block SHALL pulse the latched winner's mN_rvalid for one cycle, then return to IDLE.
- Read: mN_rdata=mem_rdata.
- Write: mN_rdata=0.
- The other master's rvalid and rdata SHALL stay at 0.
REQ-010 mN_rdata SHALL be 0 whenever mN_rvalid=0.
REQ-011 A master SHALL hold req and its payload stable until gnt; a req dropped before gnt SHALL produce no access and no response.
REQ-012 Requests raised in ACCESS or RESP SHALL wait; there is no queueing beyond the single latched transaction.
REQ-013 A write with wstrb=0 SHALL still run the full 3-cycle sequence, with mem_we=1 and mem_wstrb=0, and still return rvalid.
REQ-014 The address SHALL be passed through unmodified; the block performs no alignment checking.
REQ-015 The block SHALL keep a 1-bit last-grant pointer, updated with the winner ID on every grant.

Reset
REQ-016 While reset=1 the block SHALL go to IDLE at the next edge, set the last-grant pointer to 1, and clear the latched payload and winner ID to 0.
REQ-017 Reset SHALL force every output to 0 (gnt, rvalid, rdata, mem_we, mem_wstrb, mem_addr, mem_wdata) from the cycle following the reset edge.
REQ-018 A transaction interrupted by reset in ACCESS or RESP SHALL be aborted, with no rvalid issued afterwards; a write whose ACCESS cycle already completed is not rolled back.
REQ-019 While reset=1, gnt SHALL be 0 regardless of req.

Configuration
REQ-020 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the master that is not the last-grant pointer.
REQ-021 With ARB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority, m0 over m1; the pointer is still maintained but ignored.
REQ-022 A single requester SHALL win immediately in both builds.

Verification
REQ-023 The bench SHALL cover:
- Single read: m0 read addr 0x10, memory word 0xDEADBEEF -> m0_gnt in cycle 0, mem_addr=0x10 in cycle 1, m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 2, IDLE in cycle 3.
- Write: m1 write addr 0x20, wdata 0x12345678, wstrb 0x3 -> mem_we=1 and mem_wstrb=0x3 for exactly 1 cycle, m1_rvalid the cycle after with m1_rdata=0, m0 outputs all 0.
- Contention with ARB_ROUND_ROBIN_EN: m0 and m1 request continuously from reset release -> grant order m0, m1, m0, m1, one grant every 3 cycles.
- Contention without the macro: same stimulus -> m0 granted every time and m1 never granted.
- Reset mid-read: reset asserted in ACCESS of an m0 read -> no m0_rvalid, all outputs 0, next request granted normally; with the macro, m0 wins the first tie after reset.
- Early drop: m1_req pulsed in ACCESS of another transaction and dropped before IDLE -> no m1_gnt and no memory access for m1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master to single-memory-port arbiter: one transaction at a time, IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed priority (m0 over m1).
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit round_robin_en = 1'b1;
`else
    localparam bit round_robin_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_wstrb;
    logic              lat_id;
    logic              last_gnt;
    logic              grant_any;
    logic              grant_id;

    // Arbitration and next state. The pointer is read in both builds and only matters
    // when round-robin is enabled; a single requester always wins outright.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && (m0_req || m1_req)) begin
                    grant_any  = 1'b1;
                    if (m0_req && m1_req) grant_id = round_robin_en & ~last_gnt;
                    else                  grant_id = m1_req;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: payload registers are reset (not just the FSM) because mem_addr/mem_wdata are driven
    // straight from them and must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_id    <= 1'b0;
            last_gnt  <= 1'b1;
        end else begin
            state <= state_next;
            if (grant_any) begin
                lat_we    <= grant_id ? m1_we    : m0_we;
                lat_addr  <= grant_id ? m1_addr  : m0_addr;
                lat_wdata <= grant_id ? m1_wdata : m0_wdata;
                lat_wstrb <= grant_id ? m1_wstrb : m0_wstrb;
                lat_id    <= grant_id;
                last_gnt  <= grant_id;
            end
        end
    end

    assign m0_gnt = grant_any & ~grant_id;
    assign m1_gnt = grant_any &  grant_id;

    // Address and data come straight from the latch, so they hold between transactions;
    // write enable and strobes are qualified to the single ACCESS cycle.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_we    = (state == ACCESS) & lat_we;
    assign mem_wstrb = (state == ACCESS) ? lat_wstrb : 4'h0;

    assign m0_rvalid = (state == RESP) & ~lat_id;
    assign m1_rvalid = (state == RESP) &  lat_id;
    assign m0_rdata  = (m0_rvalid && !lat_we) ? mem_rdata : 32'h0;
    assign m1_rdata  = (m1_rvalid && !lat_we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expected grant order follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;

    int total  = 0;
    int passes = 0;

    logic [31:0] mem [16];

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data one cycle after the address, byte-masked writes.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[5:2]];
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs set here apply to the new cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},    {30'h0, m0_gnt, m1_gnt}, 32'h0);
        check({tag, " rvalid"}, {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
        check({tag, " m0_rdata"}, m0_rdata, 32'h0);
        check({tag, " m1_rdata"}, m1_rdata, 32'h0);
        check({tag, " mem_we"},   {31'h0, mem_we}, 32'h0);
        check({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        check({tag, " mem_addr"},  mem_addr, 32'h0);
        check({tag, " mem_wdata"}, mem_wdata, 32'h0);
    endtask

    logic [11:0] exp_m0_gnt, exp_m1_gnt;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;   // 0x10
        mem[8] = 32'hAAAAAAAA;   // 0x20
`ifdef ARB_ROUND_ROBIN_EN
        exp_m0_gnt = 12'h041;    // grants at cycles 0 and 6
        exp_m1_gnt = 12'h208;    // grants at cycles 3 and 9
`else
        exp_m0_gnt = 12'h249;    // grants at cycles 0, 3, 6, 9
        exp_m1_gnt = 12'h000;
`endif
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;

        // Reset: outputs cleared, gnt held low even with a request present.
        cyc();
        m0_req = 1; m1_req = 1;
        settle();
        check_all_zero("reset");
        cyc();
        m0_req = 0; m1_req = 0; reset = 1'b0;
        settle();
        check("idle no req gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);

        // Single read by m0 at 0x10.
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wdata = 32'h55; m0_wstrb = 0;
        settle();
        check("rd c0 m0_gnt", {31'h0, m0_gnt}, 32'h1);
        check("rd c0 m1_gnt", {31'h0, m1_gnt}, 32'h0);
        cyc();
        m0_req = 0;
        settle();
        check("rd c1 mem_addr", mem_addr, 32'h10);
        check("rd c1 mem_we", {31'h0, mem_we}, 32'h0);
        check("rd c1 m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        cyc();
        settle();
        check("rd c2 m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        check("rd c2 m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd c2 m1_rvalid", {31'h0, m1_rvalid}, 32'h0);

        // Cycle 3 is IDLE again: m1 write is granted at once.
        cyc();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_wstrb = 4'h3;
        settle();
        check("rd c3 m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        check("rd c3 m0_rdata", m0_rdata, 32'h0);
        check("wr c0 m1_gnt", {31'h0, m1_gnt}, 32'h1);
        check("wr c0 mem_we", {31'h0, mem_we}, 32'h0);
        cyc();
        m1_req = 0;
        settle();
        check("wr c1 mem_we", {31'h0, mem_we}, 32'h1);
        check("wr c1 mem_wstrb", {28'h0, mem_wstrb}, 32'h3);
        check("wr c1 mem_addr", mem_addr, 32'h20);
        check("wr c1 mem_wdata", mem_wdata, 32'h12345678);
        cyc();
        settle();
        check("wr c2 mem_we", {31'h0, mem_we}, 32'h0);
        check("wr c2 mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("wr c2 mem_addr hold", mem_addr, 32'h20);
        check("wr c2 m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
        check("wr c2 m1_rdata", m1_rdata, 32'h0);
        check("wr c2 m0 outs", {m0_gnt, m0_rvalid, 30'h0} | m0_rdata, 32'h0);

        // Zero-strobe write to an unaligned address by m0.
        cyc();
        m0_req = 1; m0_we = 1; m0_addr = 32'h27; m0_wdata = 32'hFFFFFFFF; m0_wstrb = 4'h0;
        settle();
        check("wr c3 m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        check("zs c0 m0_gnt", {31'h0, m0_gnt}, 32'h1);
        cyc();
        m0_req = 0;
        settle();
        check("zs c1 mem_we", {31'h0, mem_we}, 32'h1);
        check("zs c1 mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("zs c1 mem_addr", mem_addr, 32'h27);
        cyc();
        settle();
        check("zs c2 m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        check("zs c2 m0_rdata", m0_rdata, 32'h0);

        // Read back 0x20 through m1: only the low two bytes were written.
        cyc();
        m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_wstrb = 0;
        settle();
        check("rb c0 m1_gnt", {31'h0, m1_gnt}, 32'h1);
        cyc();
        m1_req = 0;
        cyc();
        settle();
        check("rb c2 m1_rdata", m1_rdata, 32'hAAAA5678);

        // Early drop: m1 pulses req during an m0 read and drops it before IDLE.
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wstrb = 0;
        settle();
        check("ed c0 m0_gnt", {31'h0, m0_gnt}, 32'h1);
        cyc();
        m0_req = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'hF;
        settle();
        check("ed c1 m1_gnt", {31'h0, m1_gnt}, 32'h0);
        cyc();
        m1_req = 0;
        settle();
        check("ed c2 m1_gnt", {31'h0, m1_gnt}, 32'h0);
        check("ed c2 m0_rdata", m0_rdata, 32'hDEADBEEF);
        cyc();
        settle();
        check("ed c3 gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);
        cyc();
        settle();
        check("ed c4 mem_we", {31'h0, mem_we}, 32'h0);
        check("ed c4 mem_addr", mem_addr, 32'h10);
        check("ed c4 m1_rvalid", {31'h0, m1_rvalid}, 32'h0);

        // Contention from reset release: both masters read continuously.
        cyc();
        reset = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_wstrb = 0;
        settle();
        check("ct reset gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            settle();
            check($sformatf("ct c%0d m0_gnt", k), {31'h0, m0_gnt}, {31'h0, exp_m0_gnt[k]});
            check($sformatf("ct c%0d m1_gnt", k), {31'h0, m1_gnt}, {31'h0, exp_m1_gnt[k]});
            cyc();
        end
        m0_req = 0; m1_req = 0;
        settle();
        check("ct drain gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);

        // Reset during ACCESS of an m0 read aborts it; pointer returns to 1.
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wdata = 32'h55; m0_wstrb = 0;
        settle();
        check("rs c0 m0_gnt", {31'h0, m0_gnt}, 32'h1);
        cyc();
        m0_req = 0; reset = 1'b1;
        settle();
        check("rs c1 mem_addr", mem_addr, 32'h10);
        cyc();
        reset = 1'b0;
        settle();
        check_all_zero("rs c2");
        cyc();
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        settle();
        check("rs c3 m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        check("rs tie m0_gnt", {31'h0, m0_gnt}, 32'h1);
        check("rs tie m1_gnt", {31'h0, m1_gnt}, 32'h0);
        cyc();
        m0_req = 0; m1_req = 0;
        cyc();
        settle();
        check("rs post m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        check("rs post m0_rdata", m0_rdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
